pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-level sequencer for the pong display pipeline. Sits beside the graphics animation unit and the VGA sync unit: it freezes or releases the animation through `gra_still`, counts remaining balls, keeps a two-digit BCD score from paddle hits, and enforces a fixed frame-count pause after a miss and after game over. All outputs are Moore outputs derived from registers, so the text/graphics overlay reads them directly without glitches.

## Interface
Parameters:
- `START_BALLS`, 3: balls per game; legal range 1-3.
- `WAIT_FRAMES`, 120: refresh ticks to wait in NEWBALL/OVER (2 s at 60 Hz); legal range 1-255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `btn`  in  2  player buttons, synchronised upstream; "pressed" means `btn != 0`.
- `refr_tick`  in  1  one-cycle pulse per frame, from the sync unit.
- `hit`  in  1  one-cycle pulse: ball struck paddle.
- `miss`  in  1  one-cycle pulse: ball passed paddle.
- `gra_still`  out  1  1 = animation frozen, ball re-centred.
- `game_state`  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `balls_left`  out  2  remaining balls.
- `score_d1`, `score_d0`  out  4 each  BCD score, tens/units.
- `hi_d1`, `hi_d0`  out  4 each  BCD high score (see Configuration).

## Operation
- Reset: state NEWGAME, `balls_left`=START_BALLS, score 00, high score 00, timer 0, `gra_still`=1.
- NEWGAME: `gra_still`=1. On pressed: score cleared to 00, `balls_left`=START_BALLS, go PLAY.
- PLAY: `gra_still`=0.
  - `hit` alone: score +1 in BCD (09->10, 99->00 wrap).
  - `miss`: if `balls_left`==1 -> `balls_left`=0, load timer, go OVER; else `balls_left`-1, load timer, go NEWBALL.
  - `hit` and `miss` same cycle: miss wins, score unchanged.
- NEWBALL: `gra_still`=1; `hit`/`miss` ignored. Go PLAY when timer==0 and pressed in the same cycle; press while timer>0 ignored (not latched).
- OVER: `gra_still`=1; go NEWGAME when timer==0. Score held for display.
- Timer: 8-bit down-counter; load = WAIT_FRAMES; decrements by 1 on `refr_tick` while nonzero; holds at 0. `hit`/`miss`/`btn` outside the states named above have no effect.
- Score and ball counter change only in the transitions listed; no other path modifies them.

## Timing
- Single clock domain; all state, counters and outputs register on rising `clk`; `reset` clears asynchronously.
- Event at edge N (miss, press, timer reaching 0) -> new state and its outputs valid after edge N, i.e. one-cycle latency.
- Timer loaded at edge N; with WAIT_FRAMES=k, exit from NEWBALL possible no earlier than the cycle after the k-th `refr_tick` following N.
- `refr_tick` on the load cycle does not decrement (load has priority).
- Reset mid-game: immediate return to NEWGAME with reset values; high score also cleared.

## Configuration
- `PONG_CTRL_HISCORE_EN` defined: high-score register; on every transition into OVER, if score > high score (BCD compare, tens then units), high score <= score. `hi_d1`/`hi_d0` drive it.
- Not defined: no high-score storage; `hi_d1`, `hi_d0` tied to 0.

## Test plan
- Reset, no stimulus 10 cycles -> `game_state`=00, `gra_still`=1, `balls_left`=3, score 00.
- NEWGAME, `btn`=01 one cycle -> next cycle `game_state`=01, `gra_still`=0; 12 `hit` pulses -> score_d1=1, score_d0=2.
- PLAY, `miss` -> `game_state`=10, `balls_left`=2, `gra_still`=1; press before 120 `refr_tick` -> stays 10; press after 120th -> 01.
- PLAY with `balls_left`=1, `hit` and `miss` together -> `game_state`=11, `balls_left`=0, score unchanged; after 120 `refr_tick` -> 00 with score still displayed until next press clears it.
- Score 99, `hit` -> 00; with PONG_CTRL_HISCORE_EN, game ending at 15 after prior 07 -> hi 15; next game ending at 03 -> hi stays 15; without macro hi stays 00.
- Assert `reset` while in NEWBALL with timer mid-count -> asynchronously `game_state`=00, timer 0, `balls_left`=3, score 00.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// pong_game_ctrl
//
// Game-level sequencer for the pong display pipeline. Freezes/releases the
// animation unit, counts remaining balls, keeps a two-digit BCD score from
// paddle hits and enforces a frame-counted pause after a miss and after the
// game is over. Every output comes straight from a register.
//
// Optional feature macro: PONG_CTRL_HISCORE_EN
//   defined     -> high-score register, updated on each entry into OVER
//   not defined -> hi_d1 / hi_d0 are tied to zero
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   btn[1:0]    player buttons (already synchronised); pressed = any bit set
//   refr_tick   one-cycle pulse per video frame
//   hit         one-cycle pulse, ball struck paddle
//   miss        one-cycle pulse, ball passed paddle
//   gra_still   1 = animation frozen, ball re-centred
//   game_state  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER
//   balls_left  remaining balls
//   score_d1/0  BCD score, tens/units
//   hi_d1/0     BCD high score
// ----------------------------------------------------------------------------
module pong_game_ctrl #(
  parameter int START_BALLS = 3,   // 1..3
  parameter int WAIT_FRAMES = 120  // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       refr_tick,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [1:0] balls_left,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [3:0] hi_d1,
  output logic [3:0] hi_d0
);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [1:0] BALLS_INIT = 2'(START_BALLS);
  localparam logic [7:0] TIMER_LOAD = 8'(WAIT_FRAMES);

  state_t     state_q, state_d;
  logic [1:0] balls_q, balls_d;
  logic [3:0] sc1_q, sc1_d;
  logic [3:0] sc0_q, sc0_d;
  logic [7:0] timer_q, timer_d;
  logic       gra_still_q, gra_still_d;
  logic       enter_over;
  logic       pressed;

  assign pressed = |btn;

  always_comb begin
    state_d    = state_q;
    balls_d    = balls_q;
    sc1_d      = sc1_q;
    sc0_d      = sc0_q;
    timer_d    = timer_q;
    enter_over = 1'b0;

    // Free-running decrement; a load below overrides it, so a tick on the
    // load cycle is lost rather than shortening the pause.
    if (refr_tick && (timer_q != 8'd0)) begin
      timer_d = timer_q - 8'd1;
    end

    case (state_q)
      ST_NEWGAME: begin
        if (pressed) begin
          sc1_d   = 4'd0;
          sc0_d   = 4'd0;
          balls_d = BALLS_INIT;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A miss takes precedence over a simultaneous hit.
        if (miss) begin
          timer_d = TIMER_LOAD;
          if (balls_q == 2'd1) begin
            balls_d    = 2'd0;
            state_d    = ST_OVER;
            enter_over = 1'b1;
          end else begin
            balls_d = balls_q - 2'd1;
            state_d = ST_NEWBALL;
          end
        end else if (hit) begin
          if (sc0_q == 4'd9) begin
            sc0_d = 4'd0;
            sc1_d = (sc1_q == 4'd9) ? 4'd0 : sc1_q + 4'd1;
          end else begin
            sc0_d = sc0_q + 4'd1;
          end
        end
      end
      ST_NEWBALL: begin
        // Press must coincide with an expired timer; early presses are dropped.
        if ((timer_q == 8'd0) && pressed) begin
          state_d = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (timer_q == 8'd0) begin
          state_d = ST_NEWGAME;
        end
      end
      default: state_d = ST_NEWGAME;
    endcase

    // Registered so the overlay sees a glitch-free freeze flag that tracks
    // the new state with the same one-cycle latency.
    gra_still_d = (state_d != ST_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_NEWGAME;
      balls_q     <= BALLS_INIT;
      sc1_q       <= 4'd0;
      sc0_q       <= 4'd0;
      timer_q     <= 8'd0;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      balls_q     <= balls_d;
      sc1_q       <= sc1_d;
      sc0_q       <= sc0_d;
      timer_q     <= timer_d;
      gra_still_q <= gra_still_d;
    end
  end

`ifdef PONG_CTRL_HISCORE_EN
  logic [3:0] hi1_q, hi1_d;
  logic [3:0] hi0_q, hi0_d;

  // BCD digits compare correctly as a plain concatenated binary value:
  // tens digit dominates, units break ties.
  always_comb begin
    hi1_d = hi1_q;
    hi0_d = hi0_q;
    if (enter_over && ({sc1_q, sc0_q} > {hi1_q, hi0_q})) begin
      hi1_d = sc1_q;
      hi0_d = sc0_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi1_q <= 4'd0;
      hi0_q <= 4'd0;
    end else begin
      hi1_q <= hi1_d;
      hi0_q <= hi0_d;
    end
  end

  assign hi_d1 = hi1_q;
  assign hi_d0 = hi0_q;
`else
  logic unused_enter_over;
  assign unused_enter_over = enter_over;
  assign hi_d1 = 4'd0;
  assign hi_d0 = 4'd0;
`endif

  assign gra_still  = gra_still_q;
  assign game_state = state_q;
  assign balls_left = balls_q;
  assign score_d1   = sc1_q;
  assign score_d0   = sc0_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pong_game_ctrl
//
// Directed testbench for pong_game_ctrl with default parameters
// (START_BALLS=3, WAIT_FRAMES=120). Expected values are hand-derived.
// High-score expectations follow PONG_CTRL_HISCORE_EN if defined.
// ----------------------------------------------------------------------------
module tb_pong_game_ctrl;

`ifdef PONG_CTRL_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [1:0] btn;
  logic       refr_tick;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic [1:0] game_state;
  logic [1:0] balls_left;
  logic [3:0] score_d1;
  logic [3:0] score_d0;
  logic [3:0] hi_d1;
  logic [3:0] hi_d0;

  int n_checks;
  int n_fails;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .refr_tick  (refr_tick),
    .hit        (hit),
    .miss       (miss),
    .gra_still  (gra_still),
    .game_state (game_state),
    .balls_left (balls_left),
    .score_d1   (score_d1),
    .score_d0   (score_d0),
    .hi_d1      (hi_d1),
    .hi_d0      (hi_d0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    btn = 2'b01;
    step();
    btn = 2'b00;
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1;
      step();
      hit = 1'b0;
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1;
    step();
    miss = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      refr_tick = 1'b1;
      step();
      refr_tick = 1'b0;
    end
  endtask

  task automatic chk_score(input string tag, input int d1, input int d0);
    chk({tag, "_d1"}, 32'(score_d1), 32'(d1));
    chk({tag, "_d0"}, 32'(score_d0), 32'(d0));
  endtask

  task automatic chk_hi(input string tag, input int d1, input int d0);
    chk({tag, "_hi1"}, 32'(hi_d1), HI_EN ? 32'(d1) : 32'd0);
    chk({tag, "_hi0"}, 32'(hi_d0), HI_EN ? 32'(d0) : 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b1;
    btn       = 2'b00;
    refr_tick = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    step(); step(); step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();

    // Reset state
    chk("rst_state", 32'(game_state), 32'd0);
    chk("rst_still", 32'(gra_still), 32'd1);
    chk("rst_balls", 32'(balls_left), 32'd3);
    chk_score("rst_score", 0, 0);
    chk_hi("rst", 0, 0);

    // Game 1: start, 12 hits
    press();
    chk("g1_start_state", 32'(game_state), 32'd1);
    chk("g1_start_still", 32'(gra_still), 32'd0);
    chk("g1_start_balls", 32'(balls_left), 32'd3);
    pulse_hit(12);
    chk_score("g1_12hits", 1, 2);

    // First miss -> NEWBALL
    pulse_miss();
    chk("g1_miss_state", 32'(game_state), 32'd2);
    chk("g1_miss_balls", 32'(balls_left), 32'd2);
    chk("g1_miss_still", 32'(gra_still), 32'd1);
    // hit/miss ignored in NEWBALL
    pulse_hit(2);
    pulse_miss();
    chk_score("g1_nb_ignore", 1, 2);
    chk("g1_nb_ignore_balls", 32'(balls_left), 32'd2);
    chk("g1_nb_ignore_state", 32'(game_state), 32'd2);
    // early presses dropped
    btn = 2'b10;
    step(); step(); step();
    btn = 2'b00;
    chk("g1_early_press", 32'(game_state), 32'd2);
    ticks(119);
    press();
    chk("g1_press_t1", 32'(game_state), 32'd2);
    // press coinciding with the 120th tick: timer still 1 at that edge
    btn = 2'b11;
    refr_tick = 1'b1;
    step();
    btn = 2'b00;
    refr_tick = 1'b0;
    chk("g1_press_on_tick120", 32'(game_state), 32'd2);
    press();
    chk("g1_resume_state", 32'(game_state), 32'd1);
    chk("g1_resume_still", 32'(gra_still), 32'd0);
    pulse_hit(3);
    chk_score("g1_15", 1, 5);

    // Second miss, then hit+miss on last ball
    pulse_miss();
    chk("g1_miss2_balls", 32'(balls_left), 32'd1);
    ticks(120);
    press();
    chk("g1_resume2_state", 32'(game_state), 32'd1);
    hit  = 1'b1;
    miss = 1'b1;
    step();
    hit  = 1'b0;
    miss = 1'b0;
    chk("g1_over_state", 32'(game_state), 32'd3);
    chk("g1_over_balls", 32'(balls_left), 32'd0);
    chk("g1_over_still", 32'(gra_still), 32'd1);
    chk_score("g1_over_score", 1, 5);
    chk_hi("g1_over", 1, 5);
    pulse_hit(1);
    chk_score("g1_over_hit_ignored", 1, 5);
    ticks(119);
    chk("g1_over_t1", 32'(game_state), 32'd3);
    ticks(1);
    chk("g1_over_t0", 32'(game_state), 32'd3);
    step();
    chk("g1_newgame_state", 32'(game_state), 32'd0);
    chk("g1_newgame_still", 32'(gra_still), 32'd1);
    chk_score("g1_newgame_held", 1, 5);

    // Game 2: ends at 03, tick on the load cycle must not count
    press();
    chk("g2_start_state", 32'(game_state), 32'd1);
    chk("g2_start_balls", 32'(balls_left), 32'd3);
    chk_score("g2_cleared", 0, 0);
    pulse_hit(3);
    miss = 1'b1;
    refr_tick = 1'b1;
    step();
    miss = 1'b0;
    refr_tick = 1'b0;
    chk("g2_miss_state", 32'(game_state), 32'd2);
    ticks(119);
    press();
    chk("g2_loadtick_hold", 32'(game_state), 32'd2);
    ticks(1);
    press();
    chk("g2_loadtick_exit", 32'(game_state), 32'd1);
    pulse_miss();
    ticks(120);
    press();
    chk("g2_last_ball", 32'(balls_left), 32'd1);
    pulse_miss();
    chk("g2_over_state", 32'(game_state), 32'd3);
    chk_score("g2_over_score", 0, 3);
    chk_hi("g2_over", 1, 5);
    ticks(120);
    step();
    chk("g2_newgame_state", 32'(game_state), 32'd0);

    // Game 3: 99 wrap, then async reset in NEWBALL mid-count
    press();
    pulse_hit(99);
    chk_score("g3_99", 9, 9);
    pulse_hit(1);
    chk_score("g3_wrap", 0, 0);
    pulse_miss();
    chk("g3_nb_state", 32'(game_state), 32'd2);
    ticks(60);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(game_state), 32'd0);
    chk("arst_balls", 32'(balls_left), 32'd3);
    chk("arst_still", 32'(gra_still), 32'd1);
    chk_score("arst_score", 0, 0);
    chk_hi("arst", 0, 0);
    step();
    reset = 1'b0;
    step(); step();
    chk("arst_hold_state", 32'(game_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
